// File: rtl/wb_stage.sv
// Writeback stage: holds one retiring instruction, aligns load data, drives the register-file write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_mem,
  output logic                  allow_in_wb,
  input  logic                  mem_we,
  input  logic [RD_WIDTH-1:0]   mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [DATA_WIDTH-1:0] mem_alu_res,
  input  logic [DATA_WIDTH-1:0] mem_pc,
  input  logic [2:0]            mem_funct3,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  input  logic                  allow_in_regfile,
  output logic                  we,
  output logic [RD_WIDTH-1:0]   wa,
  output logic [DATA_WIDTH-1:0] wd,
  output logic                  valid_wb,
  output logic                  ready_go_wb,
  output logic [63:0]           instret
);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_LD, LD_DONE} state_t;

  state_t                state, state_nxt;
  logic                  r_we;
  logic [RD_WIDTH-1:0]   r_rd;
  logic [1:0]            r_wb_sel;
  logic [DATA_WIDTH-1:0] r_alu_res;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [2:0]            r_funct3;
  logic [DATA_WIDTH-1:0] ld_buf;

  logic                  accept;
  logic                  complete;
  logic                  capture;
  logic [DATA_WIDTH-1:0] ld_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  assign valid_wb    = (state != IDLE);
  assign allow_in_wb = !valid_wb | (ready_go_wb & allow_in_regfile);
  assign accept      = valid_mem & allow_in_wb;
  assign complete    = valid_wb & ready_go_wb & allow_in_regfile;
  // Response arrived but the register file is stalled: park the word so it is not lost.
  assign capture     = (state == WAIT_LD) & dmem_rvalid & !allow_in_regfile;

  always_comb begin
    ready_go_wb = 1'b0;
    unique case (state)
      HOLD, LD_DONE: ready_go_wb = 1'b1;
      WAIT_LD:       ready_go_wb = dmem_rvalid;
      default:       ready_go_wb = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = (mem_wb_sel == 2'b01) ? WAIT_LD : HOLD;
    else if (complete)
      state_nxt = IDLE;
    else if (capture)
      state_nxt = LD_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we      <= 1'b0;
      r_rd      <= '0;
      r_wb_sel  <= '0;
      r_alu_res <= '0;
      r_pc      <= '0;
      r_funct3  <= '0;
      ld_buf    <= '0;
    end else begin
      if (accept) begin
        r_we      <= mem_we;
        r_rd      <= mem_rd;
        r_wb_sel  <= mem_wb_sel;
        r_alu_res <= mem_alu_res;
        r_pc      <= mem_pc;
        r_funct3  <= mem_funct3;
      end
      if (capture) begin
        ld_buf <= dmem_rdata;
      end
    end
  end

  assign ld_word = (state == LD_DONE) ? ld_buf : dmem_rdata;
  assign ld_byte = 8'(ld_word >> {r_alu_res[1:0], 3'b000});
  assign ld_half = 16'(ld_word >> {r_alu_res[1], 4'b0000});

  always_comb begin
    ld_data = ld_word;
    unique case (r_funct3)
      3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    wd = r_alu_res;
    unique case (r_wb_sel)
      2'b01:   wd = ld_data;
      2'b10:   wd = r_pc + DATA_WIDTH'(4);
      default: wd = r_alu_res;
    endcase
  end

  assign wa = r_rd;
  assign we = r_we & valid_wb & (r_rd != '0);

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (complete) begin
      instret <= instret + 64'd1;
    end
  end
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writebacks are queued at issue and popped on each completion.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_mem = 1'b0;
  logic        allow_in_wb;
  logic        mem_we = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [31:0] mem_alu_res = '0;
  logic [31:0] mem_pc = '0;
  logic [2:0]  mem_funct3 = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        allow_in_regfile = 1'b1;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        valid_wb;
  logic        ready_go_wb;
  logic [63:0] instret;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } exp_t;

  exp_t            sb[$];
  exp_t            e;
  int              errors = 0;
  int              checks = 0;
  longint unsigned exp_ret = 0;

`ifdef WB_INSTRET_EN
  localparam bit INSTRET_ON = 1'b1;
`else
  localparam bit INSTRET_ON = 1'b0;
`endif

  logic [1:0]  t_sel   [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01};
  logic [2:0]  t_f3    [7] = '{3'b001, 3'b100, 3'b010, 3'b000, 3'b110, 3'b000, 3'b001};
  logic [31:0] t_alu   [7] = '{32'h0, 32'h3, 32'h4, 32'h1, 32'h2, 32'h55AA, 32'h3};
  logic [31:0] t_rdata [7] = '{32'h12348001, 32'hAB000000, 32'hCAFEF00D, 32'h00007F00,
                               32'h80000001, 32'hFFFFFFFF, 32'h9ABC0000};
  logic [31:0] t_wd    [7] = '{32'hFFFF8001, 32'h000000AB, 32'hCAFEF00D, 32'h0000007F,
                               32'h80000001, 32'h000055AA, 32'hFFFF9ABC};

  wb_stage #(.DATA_WIDTH(32), .RD_WIDTH(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_mem        (valid_mem),
    .allow_in_wb      (allow_in_wb),
    .mem_we           (mem_we),
    .mem_rd           (mem_rd),
    .mem_wb_sel       (mem_wb_sel),
    .mem_alu_res      (mem_alu_res),
    .mem_pc           (mem_pc),
    .mem_funct3       (mem_funct3),
    .dmem_rvalid      (dmem_rvalid),
    .dmem_rdata       (dmem_rdata),
    .allow_in_regfile (allow_in_regfile),
    .we               (we),
    .wa               (wa),
    .wd               (wd),
    .valid_wb         (valid_wb),
    .ready_go_wb      (ready_go_wb),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
    valid_mem   = v;
    mem_we      = w;
    mem_rd      = rd;
    mem_wb_sel  = sel;
    mem_alu_res = alu;
    mem_pc      = pc;
    mem_funct3  = f3;
  endtask

  task automatic push(input logic w, input logic [4:0] rd, input logic [31:0] d);
    exp_t x;
    x.we = w && (rd != 5'd0);
    x.wa = rd;
    x.wd = d;
    sb.push_back(x);
    exp_ret++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 2'b00, 32'hFFFF, 32'h10, 3'b000);
    dmem_rvalid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL reset_valid_wb got=%b exp=0", valid_wb); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
    checks++; if (wa !== 5'd0) begin errors++; $display("FAIL reset_wa got=%0d exp=0", wa); end
    checks++; if (wd !== 32'd0) begin errors++; $display("FAIL reset_wd got=%h exp=0", wd); end
    checks++; if (ready_go_wb !== 1'b0) begin errors++; $display("FAIL reset_ready_go got=%b exp=0", ready_go_wb); end
    checks++; if (allow_in_wb !== 1'b1) begin errors++; $display("FAIL reset_allow_in got=%b exp=1", allow_in_wb); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    tick();
    valid_mem   = 1'b0;
    dmem_rvalid = 1'b0;
    rst_n       = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 5'd5, 2'b00, 32'h1234, 32'h400, 3'b000);
    push(1'b1, 5'd5, 32'h1234);
    @(negedge clk);
    checks++; if (allow_in_wb !== 1'b1) begin errors++; $display("FAIL alu_allow_in got=%b exp=1", allow_in_wb); end
    tick();
    valid_mem = 1'b0;
    @(negedge clk);
    checks++; if (valid_wb !== 1'b1) begin errors++; $display("FAIL alu_valid_wb got=%b exp=1", valid_wb); end
    checks++; if (ready_go_wb !== 1'b1) begin errors++; $display("FAIL alu_ready_go got=%b exp=1", ready_go_wb); end
    checks++;
    if (!(valid_wb && ready_go_wb && allow_in_regfile) || sb.size() == 0) begin
      errors++; $display("FAIL alu_complete got valid=%b ready=%b queued=%0d exp completion", valid_wb, ready_go_wb, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({we, wa, wd} !== {e.we, e.wa, e.wd}) begin
        errors++; $display("FAIL alu_write got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", we, wa, wd, e.we, e.wa, e.wd);
      end
    end
    tick();
    @(negedge clk);
    checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL alu_idle got=%b exp=0", valid_wb); end
    checks++; if (instret !== (INSTRET_ON ? exp_ret : 64'd0)) begin errors++; $display("FAIL alu_instret got=%0d exp=%0d", instret, INSTRET_ON ? exp_ret : 64'd0); end
    tick();
  endtask

  task automatic test_load_lb();
    drive(1'b1, 1'b1, 5'd7, 2'b01, 32'h1002, 32'h500, 3'b000);
    push(1'b1, 5'd7, 32'hFFFFFF80);
    tick();
    valid_mem   = 1'b0;
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ready_go_wb !== 1'b0) begin errors++; $display("FAIL lb_wait_ready cycle=%0d got=%b exp=0", i, ready_go_wb); end
      checks++; if (valid_wb !== 1'b1) begin errors++; $display("FAIL lb_wait_valid cycle=%0d got=%b exp=1", i, valid_wb); end
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h00800000;
    @(negedge clk);
    checks++;
    if (!(valid_wb && ready_go_wb && allow_in_regfile) || sb.size() == 0) begin
      errors++; $display("FAIL lb_complete got valid=%b ready=%b queued=%0d exp completion", valid_wb, ready_go_wb, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({we, wa, wd} !== {e.we, e.wa, e.wd}) begin
        errors++; $display("FAIL lb_write got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", we, wa, wd, e.we, e.wa, e.wd);
      end
    end
    tick();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL lb_idle got=%b exp=0", valid_wb); end
    tick();
  endtask

  task automatic test_lhu_stall();
    drive(1'b1, 1'b1, 5'd9, 2'b01, 32'h2002, 32'h600, 3'b101);
    push(1'b1, 5'd9, 32'h0000BEEF);
    tick();
    valid_mem        = 1'b0;
    allow_in_regfile = 1'b0;
    dmem_rvalid      = 1'b1;
    dmem_rdata       = 32'hBEEF0000;
    @(negedge clk);
    checks++; if (ready_go_wb !== 1'b1) begin errors++; $display("FAIL lhu_resp_ready got=%b exp=1", ready_go_wb); end
    checks++; if (allow_in_wb !== 1'b0) begin errors++; $display("FAIL lhu_resp_allow got=%b exp=0", allow_in_wb); end
    checks++; if (wd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_resp_wd got=%h exp=0000beef", wd); end
    tick();
    dmem_rdata = 32'hDEADDEAD;
    @(negedge clk);
    checks++; if (wd !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_held_wd got=%h exp=0000beef", wd); end
    checks++; if (allow_in_wb !== 1'b0) begin errors++; $display("FAIL lhu_held_allow got=%b exp=0", allow_in_wb); end
    checks++; if (valid_wb !== 1'b1) begin errors++; $display("FAIL lhu_held_valid got=%b exp=1", valid_wb); end
    tick();
    allow_in_regfile = 1'b1;
    dmem_rvalid      = 1'b0;
    @(negedge clk);
    checks++;
    if (!(valid_wb && ready_go_wb && allow_in_regfile) || sb.size() == 0) begin
      errors++; $display("FAIL lhu_complete got valid=%b ready=%b queued=%0d exp completion", valid_wb, ready_go_wb, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({we, wa, wd} !== {e.we, e.wa, e.wd}) begin
        errors++; $display("FAIL lhu_write got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", we, wa, wd, e.we, e.wa, e.wd);
      end
    end
    tick();
    @(negedge clk);
    checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL lhu_idle got=%b exp=0", valid_wb); end
    tick();
  endtask

  task automatic test_jal();
    drive(1'b1, 1'b1, 5'd0, 2'b10, 32'h0, 32'hFFFFFFFC, 3'b000);
    push(1'b1, 5'd0, 32'h00000000);
    tick();
    valid_mem = 1'b0;
    @(negedge clk);
    checks++;
    if (!(valid_wb && ready_go_wb && allow_in_regfile) || sb.size() == 0) begin
      errors++; $display("FAIL jal_complete got valid=%b ready=%b queued=%0d exp completion", valid_wb, ready_go_wb, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({we, wa, wd} !== {e.we, e.wa, e.wd}) begin
        errors++; $display("FAIL jal_write got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", we, wa, wd, e.we, e.wa, e.wd);
      end
    end
    tick();
    @(negedge clk);
    checks++; if (instret !== (INSTRET_ON ? exp_ret : 64'd0)) begin errors++; $display("FAIL jal_instret got=%0d exp=%0d", instret, INSTRET_ON ? exp_ret : 64'd0); end
    tick();
  endtask

  task automatic test_load_ext();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 5'(i + 11), t_sel[i], t_alu[i], 32'h700, t_f3[i]);
      push(1'b1, 5'(i + 11), t_wd[i]);
      tick();
      valid_mem   = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = t_rdata[i];
      @(negedge clk);
      checks++;
      if (!(valid_wb && ready_go_wb && allow_in_regfile) || sb.size() == 0) begin
        errors++; $display("FAIL ext%0d_complete got valid=%b ready=%b queued=%0d exp completion", i, valid_wb, ready_go_wb, sb.size());
      end else begin
        e = sb.pop_front();
        checks++;
        if ({we, wa, wd} !== {e.we, e.wa, e.wd}) begin
          errors++; $display("FAIL ext%0d_write got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", i, we, wa, wd, e.we, e.wa, e.wd);
        end
      end
      tick();
      dmem_rvalid = 1'b0;
    end
    @(negedge clk);
    checks++; if (instret !== (INSTRET_ON ? exp_ret : 64'd0)) begin errors++; $display("FAIL ext_instret got=%0d exp=%0d", instret, INSTRET_ON ? exp_ret : 64'd0); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 2'b00, 32'h100 + 32'(i), 32'h800, 3'b000);
      push(1'b1, 5'(i + 1), 32'h100 + 32'(i));
      @(negedge clk);
      checks++; if (allow_in_wb !== 1'b1) begin errors++; $display("FAIL b2b%0d_allow got=%b exp=1", i, allow_in_wb); end
      if (i > 0) begin
        checks++;
        if (!(valid_wb && ready_go_wb && allow_in_regfile) || sb.size() == 0) begin
          errors++; $display("FAIL b2b%0d_complete got valid=%b ready=%b queued=%0d exp completion", i, valid_wb, ready_go_wb, sb.size());
        end else begin
          e = sb.pop_front();
          checks++;
          if ({we, wa, wd} !== {e.we, e.wa, e.wd}) begin
            errors++; $display("FAIL b2b%0d_write got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", i, we, wa, wd, e.we, e.wa, e.wd);
          end
        end
      end
      tick();
    end
    valid_mem = 1'b0;
    @(negedge clk);
    checks++;
    if (!(valid_wb && ready_go_wb && allow_in_regfile) || sb.size() == 0) begin
      errors++; $display("FAIL b2b_last_complete got valid=%b ready=%b queued=%0d exp completion", valid_wb, ready_go_wb, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if ({we, wa, wd} !== {e.we, e.wa, e.wd}) begin
        errors++; $display("FAIL b2b_last_write got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", we, wa, wd, e.we, e.wa, e.wd);
      end
    end
    tick();
    @(negedge clk);
    checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", valid_wb); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain got=%0d queued exp=0", sb.size()); end
    checks++; if (instret !== (INSTRET_ON ? exp_ret : 64'd0)) begin errors++; $display("FAIL b2b_instret got=%0d exp=%0d", instret, INSTRET_ON ? exp_ret : 64'd0); end
    tick();
  endtask

  task automatic test_reset_wait_ld();
    drive(1'b1, 1'b1, 5'd10, 2'b01, 32'h3000, 32'h900, 3'b010);
    tick();
    valid_mem   = 1'b0;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (valid_wb !== 1'b1 || ready_go_wb !== 1'b0) begin errors++; $display("FAIL rst_ld_wait got valid=%b ready=%b exp valid=1 ready=0", valid_wb, ready_go_wb); end
    tick();
    rst_n   = 1'b0;
    exp_ret = 0;
    sb.delete();
    #1;
    checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL rst_ld_async got=%b exp=0", valid_wb); end
    tick();
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h11111111;
    @(negedge clk);
    checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL rst_ld_stray_valid got=%b exp=0", valid_wb); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rst_ld_stray_we got=%b exp=0", we); end
    checks++; if (ready_go_wb !== 1'b0) begin errors++; $display("FAIL rst_ld_stray_ready got=%b exp=0", ready_go_wb); end
    checks++; if (allow_in_wb !== 1'b1) begin errors++; $display("FAIL rst_ld_stray_allow got=%b exp=1", allow_in_wb); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL rst_ld_instret got=%0d exp=0", instret); end
    tick();
    dmem_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (valid_wb !== 1'b0) begin errors++; $display("FAIL rst_ld_after got=%b exp=0", valid_wb); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_lb();
    test_lhu_stall();
    test_jal();
    test_load_ext();
    test_back_to_back();
    test_reset_wait_ld();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning datapath width.
REQ-002 SHALL have parameter RD_WIDTH, default 5, meaning destination-register index width.
REQ-003 SHALL have one clock and an asynchronous active-low reset; ports listed below.
REQ-004 clk  in  1  sole clock, posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 valid_mem  in  1  MEM stage holds a valid instruction.
REQ-007 allow_in_wb  out  1  this stage accepts a new instruction this cycle.
REQ-008 mem_we  in  1  instruction writes rd.
REQ-009 mem_rd  in  RD_WIDTH  destination index.
REQ-010 mem_wb_sel  in  2  00 ALU result, 01 load data, 10 PC+4, 11 ALU result.
REQ-011 mem_alu_res  in  DATA_WIDTH  ALU result (load address for loads).
REQ-012 mem_pc  in  DATA_WIDTH  instruction PC.
REQ-013 mem_funct3  in  3  load type.
REQ-014 dmem_rvalid  in  1  data-memory read response valid.
REQ-015 dmem_rdata  in  DATA_WIDTH  data-memory read word.
REQ-016 allow_in_regfile  in  1  register file accepts writeback.
REQ-017 we  out  1  register write enable.
REQ-018 wa  out  RD_WIDTH  register write index.
REQ-019 wd  out  DATA_WIDTH  register write data.
REQ-020 valid_wb  out  1  stage holds a valid instruction.
REQ-021 ready_go_wb  out  1  held instruction completes this cycle.
REQ-022 instret  out  64  retired-instruction count.

Function
REQ-023 allow_in_wb SHALL equal !valid_wb | (ready_go_wb & allow_in_regfile).
REQ-024 Stage registers (we, rd, wb_sel, alu_res, pc, funct3) SHALL load on the posedge where valid_mem & allow_in_wb.
REQ-025 valid_wb SHALL be set on that posedge; it SHALL clear on a posedge where the instruction completes and valid_mem is low.
REQ-026 FSM states: IDLE, HOLD (non-load held), WAIT_LD (load awaiting response), LD_DONE (response captured).
REQ-027 Acceptance SHALL enter WAIT_LD if wb_sel==01, else HOLD, from any state that allows entry.
REQ-028 ready_go_wb SHALL be 1 in HOLD and LD_DONE, 1 in WAIT_LD only while dmem_rvalid is high, else 0.
REQ-029 In WAIT_LD with dmem_rvalid and allow_in_regfile low, dmem_rdata SHALL be captured and the state SHALL move to LD_DONE.
REQ-030 Completion (valid_wb & ready_go_wb & allow_in_regfile) with no new acceptance SHALL return to IDLE; with acceptance it SHALL go to HOLD or WAIT_LD per REQ-027, with zero bubble.
REQ-031 dmem_rvalid outside WAIT_LD SHALL be ignored.
REQ-032 Load data source SHALL be dmem_rdata in WAIT_LD, the captured word in LD_DONE.
REQ-033 Load extraction: byte lane alu_res[1:0], half lane alu_res[1]; funct3 000 LB sign-extend, 001 LH sign-extend, 100 LBU and 101 LHU zero-extend, all others full word.
REQ-034 wd SHALL be alu_res, extracted load data, or pc+4 modulo 2^DATA_WIDTH, per wb_sel.
REQ-035 wa SHALL equal registered rd; we SHALL equal registered we & valid_wb & (rd!=0).

Reset
REQ-036 While rst_n is low: state IDLE, valid_wb 0, we 0, wa 0, wd 0, ready_go_wb 0, allow_in_wb 1, instret 0.
REQ-037 Reset during WAIT_LD SHALL discard the pending load; a later response SHALL be ignored per REQ-031.

Configuration
REQ-038 Macro WB_INSTRET_EN defined: instret SHALL increment by 1 on each completion and wrap from 2^64-1 to 0.
REQ-039 Macro WB_INSTRET_EN undefined: instret SHALL be constant 0, with no counter logic.

Verification
REQ-040 ALU writeback rd=5, alu_res=0x1234 -> next cycle valid_wb=1, ready_go_wb=1, we=1, wa=5, wd=0x1234.
REQ-041 LB, alu_res[1:0]=2, response 0x00800000 after 3 cycles -> ready_go_wb=0 for 3 cycles, then wd=0xFFFFFF80.
REQ-042 LHU, alu_res[1]=1, rdata 0xBEEF0000, allow_in_regfile low 2 cycles at response -> LD_DONE, wd=0x0000BEEF held, completes when allow_in_regfile rises.
REQ-043 JAL pc=0xFFFFFFFC, rd=0 -> wd=0x00000000, we=0, instret+1 with WB_INSTRET_EN defined.
REQ-044 Back-to-back ALU ops valid_mem held 4 cycles -> 4 completions, no bubble, allow_in_wb stays 1.
REQ-045 rst_n low during WAIT_LD, stray dmem_rvalid after release -> state IDLE, valid_wb=0, we=0.
